cpu_multicycle_control: RTL
===========================

// Module: cpu_multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the lab CPU. Sequences each 32-bit instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Decodes opcode/funct into datapath strobes for LW, SW, J, JR, JAL, BNE, XORI, ADD, SUB and SLT.
//  Sits between the instruction memory handshake, the data memory handshake and the register file/ALU datapath.
// PARAMETERS
//  STALL_LIMIT  15  max cycles MEM may wait for dmem_ready before timeout
//  CNT_W        4   stall counter width; must satisfy 2**CNT_W > STALL_LIMIT
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   synchronous active-low reset
//  instr_valid  in   1   imem presents instr
//  instr_ready  out  1   control accepts instr (FETCH only)
//  instr        in   32  instruction word
//  dmem_ready   in   1   data memory completes access this cycle
//  alu_zero     in   1   ALU result == 0
//  ir_we        out  1   latch instr into IR
//  pc_we        out  1   update PC
//  pc_src       out  2   0=PC+4 1=BRANCH(PC+4+sext(imm)<<2) 2=JUMP({PC[31:28],tgt,2'b0}) 3=REG(rs)
//  alu_src_b    out  2   0=rt 1=sext(imm) 2=zext(imm)
//  alu_op       out  3   0=ADD 1=SUB 2=XOR 3=SLT
//  dmem_re      out  1   data memory read
//  dmem_we      out  1   data memory write
//  reg_we       out  1   register file write
//  reg_dst      out  2   0=rd 1=rt 2=$31
//  wb_src       out  2   0=ALU 1=MEM 2=PC(link)
//  illegal      out  1   sticky: undecodable opcode/funct seen
//  timeout      out  1   sticky: MEM stall exceeded STALL_LIMIT
//  state        out  3   0=FETCH 1=DECODE 2=EXEC 3=MEM 4=WB 7=HALT
// BEHAVIOUR
//  Reset, clk edge with rst_n=0: state=FETCH, IR=0, stall count=0, illegal=0, timeout=0.
//  All strobes (ir_we, pc_we, dmem_re/we, reg_we, instr_ready) are forced 0 in any cycle rst_n=0, so reset mid-MEM drops dmem_we at once.
//  Outputs are combinational from registered state+IR; unused mux selects are 0.
//  Encodings: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E.
//  R-type op 0x00: funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
//  FETCH: instr_ready=1. On instr_valid&instr_ready: ir_we=1, pc_we=1, pc_src=0 -> DECODE; else hold.
//  DECODE:
//   J: pc_we, pc_src=2 -> FETCH.
//   JAL: same, plus reg_we, reg_dst=2, wb_src=2 -> FETCH.
//   JR: pc_we, pc_src=3 -> FETCH.
//   Legal others -> EXEC. Illegal -> HALT, set illegal.
//  EXEC:
//   ADD/SUB/SLT: alu_src_b=0, alu_op per funct -> WB.
//   XORI: alu_src_b=2, alu_op=XOR -> WB.
//   LW/SW: alu_src_b=1, alu_op=ADD -> MEM.
//   BNE: alu_op=SUB, alu_src_b=0; pc_we=!alu_zero, pc_src=1 -> FETCH.
//  MEM: dmem_re (LW) or dmem_we (SW) held high until dmem_ready. Stall counter increments on each cycle without dmem_ready.
//   On dmem_ready: LW -> WB, SW -> FETCH, counter cleared.
//   Counter reaching STALL_LIMIT without dmem_ready -> HALT, set timeout; dmem strobes low next cycle.
//   dmem_ready in the same cycle as the limit is reached: completion wins.
//  WB: reg_we=1. R-type: reg_dst=0, wb_src=0. XORI: reg_dst=1, wb_src=0. LW: reg_dst=1, wb_src=1. Then -> FETCH.
//  HALT: all strobes 0, instr_ready=0; left only by reset.
//  Latency with no stalls: J/JAL/JR 2 cycles, BNE 3, SW 4, R-type/XORI 4, LW 5.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds outputs retired[31:0] and cycles[31:0].
//   Both are 0 on reset; both wrap modulo 2**32.
//   cycles increments every non-reset cycle. retired increments on each transition back to FETCH.
//  CTRL_PERF_CNT_EN undefined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//  ADD $3,$1,$2 (0x00221820), instr_valid=1 -> ir_we in cycle 1; alu_op=0 in EXEC; WB reg_we=1, reg_dst=0, wb_src=0; FETCH at cycle 5.
//  LW $5,8($4) (0x8C850008), dmem_ready low 3 cycles -> dmem_re high 4 cycles; WB reg_dst=1, wb_src=1; 8 cycles total.
//  BNE $1,$2,3 (0x14220003): alu_zero=0 -> EXEC pc_we=1, pc_src=1; alu_zero=1 -> pc_we=0; FETCH next in both cases.
//  JAL 0x0C000010 -> DECODE: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2; back in FETCH after 2 cycles.
//  Opcode 0x3F -> HALT, illegal=1, instr_ready=0 for 10 cycles; one rst_n=0 edge -> FETCH, illegal=0.
//  SW (0xAC850008) with dmem_ready held low -> timeout=1 and HALT after 15 stall cycles; rst_n pulse mid-MEM -> dmem_we=0 that cycle.

Source files
------------

// File: rtl/cpu_multicycle_control_if.sv
// Control-side bundle of the lab CPU: imem/dmem handshakes plus datapath strobes.
// master = control FSM, slave = datapath / memory side.
interface cpu_multicycle_control_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        dmem_ready;
    logic        alu_zero;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        dmem_re;
    logic        dmem_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;

    modport master (
        input  instr_valid, instr, dmem_ready, alu_zero,
        output instr_ready, ir_we, pc_we, pc_src, alu_src_b, alu_op,
               dmem_re, dmem_we, reg_we, reg_dst, wb_src
    );

    modport slave (
        output instr_valid, instr, dmem_ready, alu_zero,
        input  instr_ready, ir_we, pc_we, pc_src, alu_src_b, alu_op,
               dmem_re, dmem_we, reg_we, reg_dst, wb_src
    );
endinterface

// File: rtl/cpu_multicycle_control.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) for the lab CPU.
// Optional CTRL_PERF_CNT_EN adds retired/cycles performance counters.
module cpu_multicycle_control #(
    parameter int STALL_LIMIT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    cpu_multicycle_control_if.master       bus,
    output logic                           illegal,
    output logic                           timeout,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]                    retired,
    output logic [31:0]                    cycles,
`endif
    output logic [2:0]                     state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      ir_reg;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             illegal_reg, illegal_next;
    logic             timeout_reg, timeout_next;

    logic [5:0] op;
    logic [5:0] fn;
    logic is_rtype, is_add, is_sub, is_slt, is_jr;
    logic is_lw, is_sw, is_j, is_jal, is_bne, is_xori, is_alu_r, is_legal;

    assign op       = ir_reg[31:26];
    assign fn       = ir_reg[5:0];
    assign is_rtype = (op == 6'h00);
    assign is_add   = is_rtype && (fn == 6'h20);
    assign is_sub   = is_rtype && (fn == 6'h22);
    assign is_slt   = is_rtype && (fn == 6'h2A);
    assign is_jr    = is_rtype && (fn == 6'h08);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_bne   = (op == 6'h05);
    assign is_xori  = (op == 6'h0E);
    assign is_alu_r = is_add || is_sub || is_slt;
    assign is_legal = is_alu_r || is_jr || is_lw || is_sw || is_j || is_jal
                      || is_bne || is_xori;

    // Raw strobes before reset gating
    logic       instr_ready_c, ir_we_c, pc_we_c, dmem_re_c, dmem_we_c, reg_we_c;
    logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, wb_src_c;
    logic [2:0] alu_op_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            ir_reg        <= '0;
            stall_cnt_reg <= '0;
            illegal_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            illegal_reg   <= illegal_next;
            timeout_reg   <= timeout_next;
            if (ir_we_c) begin
                ir_reg <= bus.instr;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        stall_cnt_next = '0;
        illegal_next   = illegal_reg;
        timeout_next   = timeout_reg;
        instr_ready_c  = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        dmem_re_c      = 1'b0;
        dmem_we_c      = 1'b0;
        reg_we_c       = 1'b0;
        pc_src_c       = 2'd0;
        alu_src_b_c    = 2'd0;
        reg_dst_c      = 2'd0;
        wb_src_c       = 2'd0;
        alu_op_c       = 3'd0;

        unique case (state_reg)
            S_FETCH: begin
                instr_ready_c = 1'b1;
                if (bus.instr_valid) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_we_c    = 1'b1;
                    pc_src_c   = 2'd2;
                    state_next = S_FETCH;
                    if (is_jal) begin
                        reg_we_c  = 1'b1;
                        reg_dst_c = 2'd2;
                        wb_src_c  = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_we_c    = 1'b1;
                    pc_src_c   = 2'd3;
                    state_next = S_FETCH;
                end else if (is_legal) begin
                    state_next = S_EXEC;
                end else begin
                    illegal_next = 1'b1;
                    state_next   = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_alu_r) begin
                    alu_op_c   = is_sub ? 3'd1 : (is_slt ? 3'd3 : 3'd0);
                    state_next = S_WB;
                end else if (is_xori) begin
                    alu_src_b_c = 2'd2;
                    alu_op_c    = 3'd2;
                    state_next  = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b_c = 2'd1;
                    state_next  = S_MEM;
                end else begin
                    // Only BNE can reach EXEC otherwise
                    alu_op_c   = 3'd1;
                    pc_we_c    = !bus.alu_zero;
                    pc_src_c   = 2'd1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_re_c = is_lw;
                dmem_we_c = is_sw;
                if (bus.dmem_ready) begin
                    state_next = is_lw ? S_WB : S_FETCH;
                end else begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                    // Completion in the limit cycle takes priority over timeout
                    if (stall_cnt_reg == CNT_W'(STALL_LIMIT - 1)) begin
                        timeout_next = 1'b1;
                        state_next   = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_we_c   = 1'b1;
                state_next = S_FETCH;
                if (is_lw) begin
                    reg_dst_c = 2'd1;
                    wb_src_c  = 2'd1;
                end else if (is_xori) begin
                    reg_dst_c = 2'd1;
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    assign bus.instr_ready = instr_ready_c && rst_n;
    assign bus.ir_we       = ir_we_c && rst_n;
    assign bus.pc_we       = pc_we_c && rst_n;
    assign bus.dmem_re     = dmem_re_c && rst_n;
    assign bus.dmem_we     = dmem_we_c && rst_n;
    assign bus.reg_we      = reg_we_c && rst_n;
    assign bus.pc_src      = pc_src_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.wb_src      = wb_src_c;

    assign illegal = illegal_reg;
    assign timeout = timeout_reg;
    assign state   = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_reg;
    logic [31:0] cycles_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_reg <= '0;
            cycles_reg  <= '0;
        end else begin
            cycles_reg <= cycles_reg + 32'd1;
            if ((state_reg != S_FETCH) && (state_next == S_FETCH)) begin
                retired_reg <= retired_reg + 32'd1;
            end
        end
    end

    assign retired = retired_reg;
    assign cycles  = cycles_reg;
`endif

endmodule
